// File: rtl/audio_saw.sv
`default_nettype none
// ============================================================================
// Module      : audio_saw
// Description : Phase-accumulator sawtooth generator; the sample is the top
//               OUT_WIDTH bits of a free-running modular accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_saw #(
   parameter int ACC_WIDTH  = 27,
   parameter int FREQ_WIDTH = 16,
   parameter int OUT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [FREQ_WIDTH-1:0] freq_i,
   output logic [OUT_WIDTH-1:0]  sample_data_o
);

   logic [ACC_WIDTH-1:0] r_acc;
   logic [ACC_WIDTH-1:0] w_inc;

   // Zero-extend the increment to accumulator width; carry out of the sum is dropped.
   assign w_inc = ACC_WIDTH'(freq_i);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_acc <= '0;
      end else begin
         r_acc <= r_acc + w_inc;
      end
   end

   assign sample_data_o = r_acc[ACC_WIDTH-1 -: OUT_WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_audio_saw.sv
`default_nettype none
// Testbench for audio_saw: arithmetic phase model checked every cycle plus
// hand-computed literal expectations at key points of the ramp.
module tb_audio_saw;

   localparam longint c_MOD = 64'd134217728;  // 2^27

   logic        clk;
   logic        rstn;
   logic [15:0] freq_i;
   logic [7:0]  sample_data_o;

   int checks = 0;
   int errors = 0;
   longint model_acc = 0;

   audio_saw dut (
      .clk           (clk),
      .rstn          (rstn),
      .freq_i        (freq_i),
      .sample_data_o (sample_data_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Phase model: accumulated sum of increments modulo 2^27, cleared by reset.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) model_acc = 0;
      else       model_acc = (model_acc + longint'(freq_i)) % c_MOD;
   end

   always @(negedge clk) begin
      logic [7:0] exp_s;
      exp_s = 8'(model_acc / 524288);
      checks++;
      if (sample_data_o !== exp_s) begin
         errors++;
         $display("FAIL model_cmp t=%0t got %0d exp %0d", $time, sample_data_o, exp_s);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s got %0d exp %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Counts edges until the output drops (wrap); 0 means bound expired.
   task automatic edges_to_wrap(input int limit, output int cnt);
      int prev;
      cnt = 0;
      for (int i = 1; i <= limit; i++) begin
         prev = sample_data_o;
         tick(1);
         if (sample_data_o < prev) begin
            cnt = i;
            break;
         end
      end
   endtask

   initial begin
      int cnt;
      rstn   = 1'b0;
      freq_i = 16'd4723;
      tick(2);
      chk("reset_hold", sample_data_o, 0);

      rstn = 1'b1;
      tick(111);
      chk("edge111", sample_data_o, 0);
      tick(1);
      chk("edge112", sample_data_o, 1);
      tick(14209 - 112);
      chk("mid_0x80", sample_data_o, 128);

      // Asynchronous reset away from any clock edge
      #2;
      rstn = 1'b0;
      #1;
      chk("async_rst", sample_data_o, 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      chk("rst_released", sample_data_o, 0);

      edges_to_wrap(30000, cnt);
      chk("first_wrap_4723", cnt, 28418);
      chk("after_wrap", sample_data_o, 0);

      tick(5000);
      freq_i = 16'd9446;
      edges_to_wrap(30000, cnt);
      chk("wrap_9446_seen", (cnt != 0) ? 1 : 0, 1);
      edges_to_wrap(30000, cnt);
      chk_range("period_9446", cnt, 14208, 14209);

      // Preload to 2^27-10 then cross the top boundary
      @(posedge clk);
      #1;
      rstn = 1'b0;
      tick(1);
      rstn   = 1'b1;
      freq_i = 16'd65535;
      tick(2048);
      freq_i = 16'd2038;
      tick(1);
      chk("preload_top", sample_data_o, 255);
      freq_i = 16'd20;
      tick(1);
      chk("boundary_wrap", sample_data_o, 0);

      // Freeze near mid-scale, then resume at maximum rate
      freq_i = 16'd65535;
      tick(1024);
      chk("mid_scale", sample_data_o, 127);
      freq_i = 16'd0;
      tick(1000);
      chk("frozen", sample_data_o, 127);
      freq_i = 16'd65535;
      tick(1);
      chk("resume_1", sample_data_o, 128);
      tick(8);
      chk("resume_9", sample_data_o, 129);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/audio_saw.md
AUDIO_SAW -- requirements
Module: audio_saw

Interface
REQ-001 Parameter ACC_WIDTH, default 27, phase-accumulator width in bits.
REQ-002 Parameter FREQ_WIDTH, default 16, frequency-increment width in bits.
REQ-003 Parameter OUT_WIDTH, default 8, sample width in bits; SHALL be <= ACC_WIDTH.
REQ-004 clk  input  1  clock clk; all state updates on rising edge; nominal 12.5 MHz.
REQ-005 rstn  input  1  reset rstn, asynchronous, active-low.
REQ-006 freq_i  input  FREQ_WIDTH  unsigned phase increment per clock; f_out = freq_i * f_clk / 2^ACC_WIDTH.
REQ-007 sample_data_o  output  OUT_WIDTH  unsigned sawtooth sample, 0 = minimum, all-ones = maximum.

Function
REQ-008 The block SHALL hold one ACC_WIDTH-bit unsigned phase-accumulator register, acc.
REQ-009 On every rising clk edge with rstn high, acc SHALL become (acc + zero-extended freq_i) mod 2^ACC_WIDTH.
REQ-010 sample_data_o SHALL equal acc[ACC_WIDTH-1 : ACC_WIDTH-OUT_WIDTH], driven directly from the register with no combinational path from freq_i.
REQ-011 The output SHALL be a rising ramp that wraps from its maximum code to 0 within a single clock; there is no falling slope and no clipping.
REQ-012 Carry out of the accumulator MSB SHALL be discarded; wrap-around SHALL be modular and SHALL preserve phase continuity, with the residual low bits kept.
REQ-013 freq_i SHALL be sampled every cycle; a change SHALL take effect on the next rising edge without resetting phase.
REQ-014 freq_i = 0 SHALL freeze acc and sample_data_o at their current values.
REQ-015 Latency SHALL be one cycle: the increment sampled at edge k is reflected in sample_data_o after edge k.
REQ-016 After n edges with constant freq_i = F following reset release, acc SHALL equal (n*F) mod 2^ACC_WIDTH.
REQ-017 With default parameters and f_clk = 12.5 MHz, freq_i = 4723 SHALL produce about 439.9 Hz with a period of about 28418 clocks.
REQ-018 The block SHALL have no handshake and no valid signal; sample_data_o is valid every cycle and downstream logic decimates as needed.

Reset
REQ-019 While rstn is low, acc SHALL be 0 and sample_data_o SHALL be 0, asynchronously and independent of clk.
REQ-020 Reset asserted mid-ramp SHALL clear the output immediately; after release, the ramp SHALL restart from 0 on the first rising edge with rstn high.
REQ-021 Reset release SHALL be synchronized externally; the block adds no synchronizer.

Verification
REQ-022 Hold rstn low with freq_i = 4723 for 2 clocks -> sample_data_o = 0 throughout.
REQ-023 Release rstn with freq_i = 4723 -> acc = 4723*n after n edges; sample_data_o first becomes 1 after edge 112 (4723*112 = 528976 >= 2^19); one full 0..255..0 cycle completes every 28418 or 28419 clocks; an output sampled every 260 clocks (48 kHz) gives a 440 Hz sawtooth.
REQ-024 Preload acc to 2^27 - 10 via the increment sequence, then freq_i = 20 -> after one edge acc = 10 and sample_data_o goes from 255 to 0.
REQ-025 freq_i = 0 after ramp has reached mid-scale -> sample_data_o constant for 1000 clocks; then freq_i = 65535 -> output increments by 1 about every 8 clocks from the frozen value.
REQ-026 Assert rstn low asynchronously, away from a clock edge, while sample_data_o = 0x80 -> output = 0 before the next clk edge; after release the ramp restarts from 0.
REQ-027 Change freq_i from 4723 to 9446 mid-ramp -> no discontinuity in sample_data_o at the change; the measured period halves to about 14209 clocks.
